// File: rtl/sw_alloc_rr.sv
// Switch allocator: per-output round-robin arbiter with wormhole locking and credit flow control.
// Grants, crossbar selects and output valids are combinational from requests and registered state.
module sw_alloc_rr #(
    parameter int unsigned PORT_N    = 5,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORT_N-1:0]         req_i,
    input  logic [PORT_N*PORT_N-1:0]  port_i,
    input  logic [PORT_N-1:0]         tail_i,
    input  logic [PORT_N-1:0]         credit_i,
    output logic [PORT_N-1:0]         grant_o,
    output logic [PORT_N*PORT_N-1:0]  sel_o,
    output logic [PORT_N-1:0]         out_valid_o,
    output logic [PORT_N*CNT_W-1:0]   credit_cnt_o
);

    localparam int unsigned IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e           state_q [PORT_N];
    state_e           state_d [PORT_N];
    logic [IDX_W-1:0] owner_q [PORT_N];
    logic [IDX_W-1:0] owner_d [PORT_N];
    logic [IDX_W-1:0] ptr_q   [PORT_N];
    logic [IDX_W-1:0] ptr_d   [PORT_N];
    logic [CNT_W-1:0] cnt_q   [PORT_N];
    logic [CNT_W-1:0] cnt_d   [PORT_N];

    logic [PORT_N-1:0]        req_mat [PORT_N];
    logic [PORT_N-1:0]        gnt;
    logic [PORT_N*PORT_N-1:0] sel;
    logic [PORT_N-1:0]        vld;

    // Multi-hot destinations resolve to their lowest set bit.
    always_comb begin
        logic [PORT_N-1:0] dst;
        dst = '0;
        for (int j = 0; j < PORT_N; j++) begin
            req_mat[j] = '0;
        end
        for (int i = 0; i < PORT_N; i++) begin
            dst = port_i[i*PORT_N +: PORT_N];
            dst = dst & (~dst + PORT_N'(1));
            for (int j = 0; j < PORT_N; j++) begin
                req_mat[j][i] = req_i[i] & dst[j];
            end
        end
    end

    always_comb begin
        logic found;
        logic granted;
        int   win;
        found   = 1'b0;
        granted = 1'b0;
        win     = 0;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        sel     = '0;
        vld     = '0;
        for (int j = 0; j < PORT_N; j++) begin
            found   = 1'b0;
            granted = 1'b0;
            win     = 0;
            if (state_q[j] == StIdle) begin
                for (int k = 0; k < PORT_N; k++) begin
                    if (!found && req_mat[j][(int'(ptr_q[j]) + k) % PORT_N]) begin
                        found = 1'b1;
                        win   = (int'(ptr_q[j]) + k) % PORT_N;
                    end
                end
            end else if (req_mat[j][owner_q[j]]) begin
                found = 1'b1;
                win   = int'(owner_q[j]);
            end

            if (found && cnt_q[j] != '0) begin
                granted             = 1'b1;
                gnt[win]            = 1'b1;
                sel[j*PORT_N + win] = 1'b1;
                vld[j]              = 1'b1;
                if (tail_i[win]) begin
                    state_d[j] = StIdle;
                    ptr_d[j]   = IDX_W'((win + 1) % PORT_N);
                end else begin
                    state_d[j] = StLocked;
                    owner_d[j] = IDX_W'(win);
                end
            end

            // A returned credit and a consumed slot in the same cycle cancel out.
            if (granted && !credit_i[j]) begin
                cnt_d[j] = cnt_q[j] - CNT_W'(1);
            end else if (!granted && credit_i[j] && cnt_q[j] < CNT_W'(BUF_DEPTH)) begin
                cnt_d[j] = cnt_q[j] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < PORT_N; j++) begin
                state_q[j] <= StIdle;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
                cnt_q[j]   <= CNT_W'(BUF_DEPTH);
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        grant_o      = '0;
        sel_o        = '0;
        out_valid_o  = '0;
        credit_cnt_o = '0;
        if (!rst) begin
            grant_o     = gnt;
            sel_o       = sel;
            out_valid_o = vld;
            for (int j = 0; j < PORT_N; j++) begin
                credit_cnt_o[j*CNT_W +: CNT_W] = cnt_q[j];
            end
        end
    end

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed bench for sw_alloc_rr: expectations are queued per step and popped against the outputs.
module tb_sw_alloc_rr;

    localparam int N  = 5;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_i;
    logic [N*N-1:0]   port_i;
    logic [N-1:0]     tail_i;
    logic [N-1:0]     credit_i;
    logic [N-1:0]     grant_o;
    logic [N*N-1:0]   sel_o;
    logic [N-1:0]     out_valid_o;
    logic [N*CW-1:0]  credit_cnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [24:0] val;
    } exp_t;

    exp_t sb[$];

    sw_alloc_rr #(.PORT_N(N), .BUF_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .port_i      (port_i),
        .tail_i      (tail_i),
        .credit_i    (credit_i),
        .grant_o     (grant_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .credit_cnt_o(credit_cnt_o)
    );

    always #5 clk = ~clk;

    // Kinds: 0 grant, 1 sel, 2 out_valid, 3 credit counters.
    function automatic logic [24:0] obs(input int kind);
        case (kind)
            0:       return {20'b0, grant_o};
            1:       return sel_o;
            2:       return {20'b0, out_valid_o};
            default: return {10'b0, credit_cnt_o};
        endcase
    endfunction

    function automatic logic [24:0] pt(input int d0, input int d1, input int d2, input int d3,
                                       input int d4);
        logic [24:0] p;
        int          d [N];
        p = '0;
        d = '{d0, d1, d2, d3, d4};
        for (int i = 0; i < N; i++) begin
            if (d[i] >= 0) p[i*N + d[i]] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [24:0] sl(input int o, input int i);
        logic [24:0] s;
        s = '0;
        s[o*N + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [24:0] cn(input int c0, input int c1, input int c2, input int c3,
                                       input int c4);
        logic [14:0] c;
        c = {CW'(c4), CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
        return {10'b0, c};
    endfunction

    task automatic push(input string tag, input int kind, input logic [24:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [24:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.kind);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    // Apply inputs at the falling edge and settle before the next rising edge.
    task automatic step(input logic [4:0] r, input logic [24:0] p, input logic [4:0] t,
                        input logic [4:0] c);
        @(negedge clk);
        req_i    = r;
        port_i   = p;
        tail_i   = t;
        credit_i = c;
        #1;
    endtask

    task automatic gv(input string tag, input logic [4:0] g, input logic [4:0] v);
        push({tag, ".grant"}, 0, {20'b0, g});
        push({tag, ".valid"}, 2, {20'b0, v});
    endtask

    initial begin
        rst      = 1'b1;
        req_i    = '0;
        port_i   = '0;
        tail_i   = '0;
        credit_i = '0;
        repeat (2) @(negedge clk);

        // Outputs held at zero during reset even with a live request.
        step(5'b00001, pt(2, -1, -1, -1, -1), 5'b00001, 5'b00000);
        gv("rst_hold", 5'b00000, 5'b00000);
        push("rst_hold.sel", 1, '0);
        push("rst_hold.cnt", 3, '0);
        drain();

        @(negedge clk);
        rst = 1'b0;
        req_i = '0;
        #1;
        push("rst_rel.cnt", 3, cn(4, 4, 4, 4, 4));
        push("rst_rel.grant", 0, '0);
        drain();

        // Single flit, then pointer advance observed through arbitration.
        step(5'b00001, pt(2, -1, -1, -1, -1), 5'b00001, 5'b00000);
        gv("t1_single", 5'b00001, 5'b00100);
        push("t1_single.sel", 1, sl(2, 0));
        push("t1_single.cnt", 3, cn(4, 4, 4, 4, 4));
        drain();
        step(5'b00011, pt(2, 2, -1, -1, -1), 5'b00011, 5'b00100);
        gv("t1_ptr", 5'b00010, 5'b00100);
        push("t1_ptr.cnt", 3, cn(4, 4, 3, 4, 4));
        drain();
        step(5'b00000, '0, 5'b00000, 5'b00100);
        push("t1_gc.cnt", 3, cn(4, 4, 3, 4, 4));
        drain();

        // Round-robin among inputs 0, 1, 3 on output 4 with credits returned.
        begin
            logic [4:0] order [6];
            order = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
            for (int k = 0; k < 6; k++) begin
                step(5'b01011, pt(4, 4, -1, 4, -1), 5'b01011, 5'b10000);
                gv($sformatf("t2_rr%0d", k), order[k], 5'b10000);
                push($sformatf("t2_rr%0d.cnt", k), 3, cn(4, 4, 4, 4, 4));
                drain();
            end
        end

        // Wormhole lock: input 1 holds output 0, including across an idle gap.
        step(5'b00110, pt(-1, 0, 0, -1, -1), 5'b00100, 5'b00001);
        gv("t3_head", 5'b00010, 5'b00001);
        push("t3_head.sel", 1, sl(0, 1));
        drain();
        step(5'b00100, pt(-1, -1, 0, -1, -1), 5'b00100, 5'b00001);
        gv("t3_gap", 5'b00000, 5'b00000);
        drain();
        step(5'b00110, pt(-1, 0, 0, -1, -1), 5'b00100, 5'b00001);
        gv("t3_body", 5'b00010, 5'b00001);
        drain();
        step(5'b00110, pt(-1, 0, 0, -1, -1), 5'b00110, 5'b00001);
        gv("t3_tail", 5'b00010, 5'b00001);
        drain();
        step(5'b00100, pt(-1, -1, 0, -1, -1), 5'b00100, 5'b00001);
        gv("t3_next", 5'b00100, 5'b00001);
        push("t3_next.cnt", 3, cn(4, 4, 4, 4, 4));
        drain();

        // Credit stall: input 3 streams to output 1 without credits.
        for (int k = 0; k < 4; k++) begin
            step(5'b01000, pt(-1, -1, -1, 1, -1), 5'b00000, 5'b00000);
            gv($sformatf("t4_flit%0d", k), 5'b01000, 5'b00010);
            push($sformatf("t4_flit%0d.cnt", k), 3, cn(4, 4 - k, 4, 4, 4));
            drain();
        end
        step(5'b01001, pt(1, -1, -1, 1, -1), 5'b00000, 5'b00000);
        gv("t4_stall", 5'b00000, 5'b00000);
        push("t4_stall.cnt", 3, cn(4, 0, 4, 4, 4));
        drain();
        step(5'b01000, pt(-1, -1, -1, 1, -1), 5'b00000, 5'b00010);
        gv("t4_crpulse", 5'b00000, 5'b00000);
        drain();
        step(5'b01000, pt(-1, -1, -1, 1, -1), 5'b00000, 5'b00000);
        gv("t4_resume", 5'b01000, 5'b00010);
        push("t4_resume.cnt", 3, cn(4, 1, 4, 4, 4));
        drain();
        step(5'b00000, '0, 5'b00000, 5'b00010);
        push("t4_empty.cnt", 3, cn(4, 0, 4, 4, 4));
        drain();
        step(5'b00000, '0, 5'b00000, 5'b00010);

        // Grant and credit together at cnt=2, then saturation at 4.
        step(5'b01000, pt(-1, -1, -1, 1, -1), 5'b01000, 5'b00010);
        gv("t5_gc", 5'b01000, 5'b00010);
        push("t5_gc.cnt", 3, cn(4, 2, 4, 4, 4));
        drain();
        step(5'b01001, pt(1, -1, -1, 1, -1), 5'b01001, 5'b00000);
        gv("t5_unlock", 5'b00001, 5'b00010);
        push("t5_unlock.cnt", 3, cn(4, 2, 4, 4, 4));
        drain();
        for (int k = 0; k < 4; k++) begin
            step(5'b00000, '0, 5'b00000, 5'b00010);
        end
        step(5'b00000, '0, 5'b00000, 5'b00000);
        push("t5_sat.cnt", 3, cn(4, 4, 4, 4, 4));
        drain();

        // Asynchronous reset while output 0 is locked by input 2.
        step(5'b00100, pt(-1, -1, 0, -1, -1), 5'b00000, 5'b00000);
        gv("t6_head", 5'b00100, 5'b00001);
        drain();
        #2;
        rst = 1'b1;
        #1;
        gv("t6_async", 5'b00000, 5'b00000);
        push("t6_async.sel", 1, '0);
        push("t6_async.cnt", 3, '0);
        drain();
        req_i = '0;
        @(negedge clk);
        rst = 1'b0;
        step(5'b10010, pt(-1, 0, -1, -1, 0), 5'b10010, 5'b00000);
        gv("t6_after", 5'b00010, 5'b00001);
        push("t6_after.sel", 1, sl(0, 1));
        push("t6_after.cnt", 3, cn(4, 4, 4, 4, 4));
        drain();

        // Multi-hot destination, zero destination and independent outputs.
        begin
            logic [24:0] p;
            p = pt(-1, -1, -1, 3, -1);
            p[4:0] = 5'b10110;
            step(5'b01011, p, 5'b01011, 5'b00000);
        end
        gv("t7_multi", 5'b01001, 5'b01010);
        push("t7_multi.sel", 1, sl(1, 0) | sl(3, 3));
        push("t7_multi.cnt", 3, cn(3, 4, 4, 4, 4));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_alloc_rr.md
Name: sw_alloc_rr

Overview:
- Switch allocator for one NoC router. It sits between the PORT_N input channels (each driving req_o / port_o) and the router crossbar.
- Each output port has its own round-robin arbiter with wormhole packet locking and credit-based flow control toward the downstream buffer.
- It produces per-input grants and per-output one-hot crossbar selects in the same cycle as the request.

Parameters:
- PORT_N, 5, number of router ports (inputs = outputs).
- BUF_DEPTH, 4, downstream input-buffer depth per output port; this is the initial and maximum credit count.
- CNT_W, $clog2(BUF_DEPTH+1), credit counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  PORT_N  input i presents a flit for transfer this cycle
- port_i  in  PORT_N*PORT_N  slice [i*PORT_N +: PORT_N] is the one-hot destination output of input i
- tail_i  in  PORT_N  flit presented by input i is a tail (a single-flit packet sets tail=1)
- credit_i  in  PORT_N  one-cycle pulse: downstream of output j freed one buffer slot
- grant_o  out  PORT_N  input i's flit is transferred this cycle
- sel_o  out  PORT_N*PORT_N  slice [j*PORT_N +: PORT_N] is the one-hot input selected for output j, or zero
- out_valid_o  out  PORT_N  output j carries a valid flit this cycle
- credit_cnt_o  out  PORT_N*CNT_W  per-output credit counter, for debug and verification

Behaviour:

Reset (rst=1, asynchronous):
- All outputs are forced to 0 while rst is high.
- Internal state on reset: every output FSM = IDLE, owner = 0, rr_ptr = 0, credit count = BUF_DEPTH.
- Reset asserted mid-packet drops the lock immediately. No grant occurs until the first rising edge after release.

Request decode:
- Input i requests output j iff req_i[i] and port_i[i][j] are both set.
- port_i all-zero: no request.
- port_i multi-hot: the lowest set bit is used.
- Each input targets exactly one output, so grant_o is at most one bit per input.

Per-output FSM, states IDLE and LOCKED. The registers are owner, rr_ptr and cnt.

IDLE:
- Candidates are the inputs requesting j.
- If cnt > 0 and at least one candidate exists, the winner is the first candidate scanning from rr_ptr upward, mod PORT_N.
- A grant is issued combinationally in the same cycle: grant_o[w]=1, sel_o[j]=onehot(w), out_valid_o[j]=1.
- Winner's tail_i=1: stay IDLE; rr_ptr <= (w+1) mod PORT_N.
- Winner's tail_i=0: go to LOCKED; owner <= w; rr_ptr unchanged.

LOCKED:
- Only owner may be granted, and only when the owner requests j and cnt > 0. All other requests to j are blocked.
- Granted flit with tail=1: go to IDLE; rr_ptr <= (owner+1) mod PORT_N.
- No grant (owner idle, or cnt = 0): hold LOCKED. The lock is never broken by other requesters.

Credits, per output:
- Grant only: cnt - 1. credit_i only: cnt + 1. Both in the same cycle: cnt unchanged.
- cnt never underflows, because grant requires cnt > 0.
- credit_i while cnt = BUF_DEPTH with no grant is ignored; cnt saturates.

Latency and datapath:
- Combinational from inputs plus registered state to grant_o, sel_o and out_valid_o (0-cycle).
- State, pointer and counter updates take effect at the next rising edge.
- The block has no datapath flops. The crossbar uses sel_o directly.

Independence:
- Output arbiters are independent. Different outputs may grant different inputs in the same cycle.

Test Plan:
1. Reset and single flit: release rst; input 0 requests output 2 with tail=1 → same cycle grant_o=00001, sel_o[2]=00001, out_valid_o[2]=1; next cycle cnt[2]=3 and rr_ptr[2]=1.
2. Round-robin: inputs 0, 1 and 3 all request output 4 with single-flit packets every cycle, credits returned each cycle → grant order 0, 1, 3, 0, 1, 3; cnt[4] stays 4.
3. Wormhole lock: input 1 sends to output 0 head, body, tail on consecutive cycles while input 2 also requests output 0 → input 1 is granted 3 cycles; input 2 is granted on cycle 4; FSM goes IDLE→LOCKED→LOCKED→IDLE.
4. Credit stall: BUF_DEPTH=4, no credit_i, input 3 streams a 6-flit packet to output 1 → 4 grants, then grant_o[3]=0 with the FSM still LOCKED; a credit_i[1] pulse → exactly one more grant the next cycle.
5. Simultaneous grant and credit: cnt=2, grant and credit_i in the same cycle → cnt stays 2; credit_i at cnt=4 with no grant → cnt stays 4.
6. Async reset mid-packet: assert rst between cycle edges while output 0 is LOCKED → outputs go 0 immediately; after release, a new requester from a different input is granted under IDLE arbitration starting at ptr 0.
